bsg_axil_cmd_master: RTL and testbench

Consumes packed command words from a valid/ready stream and replays each one as a single AXI4-Lite master transaction: one write (AW+W+B) or one read (AR+R). Read data returns on a valid/ready response port. This is the far end of the host-side command packer: packed {write, addr, data} words arrive over a stream link and are executed against an AXI-Lite slave on the PL side. Exactly one transaction is outstanding at any time.

---
 rtl/bsg_axil_cmd_master_if.sv | 64 ++++++
 rtl/bsg_axil_cmd_master.sv | 163 ++++++++++++++++
 tb/tb_bsg_axil_cmd_master.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_axil_cmd_master_if.sv
// rtl/bsg_axil_cmd_master_if.sv - command/response stream plus AXI4-Lite master channels
// Signal suffixes are named from the command master's point of view.
interface bsg_axil_cmd_master_if #(
   parameter int axil_data_width_p = 32,
   parameter int axil_addr_width_p = 32
);
   logic                           v_i;
   logic [axil_data_width_p-1:0]   data_i;
   logic                           ready_o;
   logic                           v_o;
   logic [axil_data_width_p-1:0]   data_o;
   logic                           ready_i;
   logic                           error_o;

   logic [axil_addr_width_p-1:0]   m_axil_awaddr_o;
   logic [2:0]                     m_axil_awprot_o;
   logic                           m_axil_awvalid_o;
   logic                           m_axil_awready_i;
   logic [axil_data_width_p-1:0]   m_axil_wdata_o;
   logic [axil_data_width_p/8-1:0] m_axil_wstrb_o;
   logic                           m_axil_wvalid_o;
   logic                           m_axil_wready_i;
   logic [1:0]                     m_axil_bresp_i;
   logic                           m_axil_bvalid_i;
   logic                           m_axil_bready_o;
   logic [axil_addr_width_p-1:0]   m_axil_araddr_o;
   logic [2:0]                     m_axil_arprot_o;
   logic                           m_axil_arvalid_o;
   logic                           m_axil_arready_i;
   logic [axil_data_width_p-1:0]   m_axil_rdata_i;
   logic [1:0]                     m_axil_rresp_i;
   logic                           m_axil_rvalid_i;
   logic                           m_axil_rready_o;

   modport master (
      input  v_i, data_i, ready_i,
      output ready_o, v_o, data_o, error_o,
      output m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
      input  m_axil_awready_i,
      output m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o,
      input  m_axil_wready_i,
      input  m_axil_bresp_i, m_axil_bvalid_i,
      output m_axil_bready_o,
      output m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o,
      input  m_axil_arready_i,
      input  m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i,
      output m_axil_rready_o
   );

   modport slave (
      output v_i, data_i, ready_i,
      input  ready_o, v_o, data_o, error_o,
      input  m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
      output m_axil_awready_i,
      input  m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o,
      output m_axil_wready_i,
      output m_axil_bresp_i, m_axil_bvalid_i,
      input  m_axil_bready_o,
      input  m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o,
      output m_axil_arready_i,
      output m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i,
      input  m_axil_rready_o
   );
endinterface

// File: rtl/bsg_axil_cmd_master.sv
// rtl/bsg_axil_cmd_master.sv - replays packed {wr, addr, wdata} commands as single AXI4-Lite transactions
// Optional BSG_AXIL_CMD_MASTER_WRITE_ACK_EN: writes also return a {bresp} response word.
module bsg_axil_cmd_master #(
   parameter int axil_data_width_p    = 32,
   parameter int axil_addr_width_p    = 32,
   parameter int payload_addr_width_p = 15,
   parameter int payload_data_width_p = 16,
   parameter logic [axil_addr_width_p-1:0] base_addr_p = '0
) (
   input  logic clk_i,
   input  logic reset_i,
   bsg_axil_cmd_master_if.master bus
);
   typedef enum logic [2:0] {
      e_ready, e_write_req, e_write_resp, e_read_req, e_read_resp, e_resp_out
   } state_e;

   state_e                         r_state;
   logic                           r_ready;
   logic                           r_awvalid;
   logic                           r_wvalid;
   logic                           r_bready;
   logic                           r_arvalid;
   logic                           r_rready;
   logic                           r_v;
   logic                           r_error;
   logic                           r_aw_done;
   logic                           r_w_done;
   logic [axil_addr_width_p-1:0]   r_addr;
   logic [axil_data_width_p-1:0]   r_wdata;
   logic [axil_data_width_p-1:0]   r_rdata;

   logic                            w_cmd_wr;
   logic [payload_addr_width_p-1:0] w_cmd_addr;
   logic [payload_data_width_p-1:0] w_cmd_data;
   logic [axil_addr_width_p-1:0]    w_byte_addr;
   logic                            w_aw_hs;
   logic                            w_w_hs;
   logic                            w_aw_fin;
   logic                            w_w_fin;

   assign w_cmd_wr    = bus.data_i[axil_data_width_p-1];
   assign w_cmd_addr  = bus.data_i[payload_data_width_p +: payload_addr_width_p];
   assign w_cmd_data  = bus.data_i[payload_data_width_p-1:0];
   // Word address to byte address; the shift and add wrap naturally at the bus width.
   assign w_byte_addr = base_addr_p + (axil_addr_width_p'(w_cmd_addr) << 2);

   assign w_aw_hs  = r_awvalid & bus.m_axil_awready_i;
   assign w_w_hs   = r_wvalid & bus.m_axil_wready_i;
   assign w_aw_fin = r_aw_done | w_aw_hs;
   assign w_w_fin  = r_w_done | w_w_hs;

   assign bus.ready_o          = r_ready;
   assign bus.v_o              = r_v;
   assign bus.data_o           = r_v ? r_rdata : '0;
   assign bus.error_o          = r_error;
   assign bus.m_axil_awaddr_o  = r_addr;
   assign bus.m_axil_awprot_o  = 3'b000;
   assign bus.m_axil_awvalid_o = r_awvalid;
   assign bus.m_axil_wdata_o   = r_wdata;
   assign bus.m_axil_wstrb_o   = '1;
   assign bus.m_axil_wvalid_o  = r_wvalid;
   assign bus.m_axil_bready_o  = r_bready;
   assign bus.m_axil_araddr_o  = r_addr;
   assign bus.m_axil_arprot_o  = 3'b000;
   assign bus.m_axil_arvalid_o = r_arvalid;
   assign bus.m_axil_rready_o  = r_rready;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= e_ready;
         r_ready   <= 1'b1;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_v       <= 1'b0;
         r_error   <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
      end else begin
         case (r_state)
            e_ready: begin
               if (bus.v_i && r_ready) begin
                  r_ready <= 1'b0;
                  r_addr  <= w_byte_addr;
                  r_wdata <= axil_data_width_p'(w_cmd_data);
                  if (w_cmd_wr) begin
                     r_state   <= e_write_req;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_state   <= e_read_req;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            e_write_req: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               // Later assignments win, so same-cycle completion clears the flags here.
               if (w_aw_fin && w_w_fin) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= e_write_resp;
               end
            end
            e_write_resp: begin
               if (bus.m_axil_bvalid_i) begin
                  r_bready <= 1'b0;
                  if (bus.m_axil_bresp_i != 2'b00) r_error <= 1'b1;
`ifdef BSG_AXIL_CMD_MASTER_WRITE_ACK_EN
                  r_rdata <= axil_data_width_p'(bus.m_axil_bresp_i);
                  r_v     <= 1'b1;
                  r_state <= e_resp_out;
`else
                  r_ready <= 1'b1;
                  r_state <= e_ready;
`endif
               end
            end
            e_read_req: begin
               if (bus.m_axil_arready_i) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= e_read_resp;
               end
            end
            e_read_resp: begin
               if (bus.m_axil_rvalid_i) begin
                  r_rready <= 1'b0;
                  r_rdata  <= bus.m_axil_rdata_i;
                  if (bus.m_axil_rresp_i != 2'b00) r_error <= 1'b1;
                  r_v      <= 1'b1;
                  r_state  <= e_resp_out;
               end
            end
            e_resp_out: begin
               if (bus.ready_i) begin
                  r_v     <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= e_ready;
               end
            end
            default: begin
               r_state <= e_ready;
               r_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bsg_axil_cmd_master.sv
// tb/tb_bsg_axil_cmd_master.sv - self-checking bench for bsg_axil_cmd_master
// A transaction-level model predicts every AXI beat and response word; directed tests pin it.
module tb_bsg_axil_cmd_master;
   localparam int D = 32;
   localparam int A = 32;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic clk_i = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk_i = ~clk_i;

   bsg_axil_cmd_master_if #(.axil_data_width_p(D), .axil_addr_width_p(A)) bus ();

   bsg_axil_cmd_master #(
      .axil_data_width_p(D), .axil_addr_width_p(A),
      .payload_addr_width_p(15), .payload_data_width_p(16), .base_addr_p(BASE)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .bus(bus.master)
   );

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Slave behaviour knobs
   int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0, resp_delay = 0;
   logic [1:0]  slv_bresp = 2'b00;
   logic [1:0]  slv_rresp = 2'b00;
   logic [31:0] slv_rdata = 32'h0;

   initial begin
      int aw_c, w_c, ar_c, b_c, r_c, o_c;
      aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; o_c = 0;
      bus.m_axil_awready_i = 1'b0;
      bus.m_axil_wready_i  = 1'b0;
      bus.m_axil_bvalid_i  = 1'b0;
      bus.m_axil_bresp_i   = 2'b00;
      bus.m_axil_arready_i = 1'b0;
      bus.m_axil_rvalid_i  = 1'b0;
      bus.m_axil_rresp_i   = 2'b00;
      bus.m_axil_rdata_i   = 32'h0;
      bus.ready_i          = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         if (bus.m_axil_awvalid_o) begin bus.m_axil_awready_i = (aw_c >= aw_delay); aw_c++; end
         else begin bus.m_axil_awready_i = 1'b0; aw_c = 0; end
         if (bus.m_axil_wvalid_o) begin bus.m_axil_wready_i = (w_c >= w_delay); w_c++; end
         else begin bus.m_axil_wready_i = 1'b0; w_c = 0; end
         if (bus.m_axil_arvalid_o) begin bus.m_axil_arready_i = (ar_c >= ar_delay); ar_c++; end
         else begin bus.m_axil_arready_i = 1'b0; ar_c = 0; end
         if (bus.m_axil_bready_o) begin bus.m_axil_bvalid_i = (b_c >= b_delay); b_c++; end
         else begin bus.m_axil_bvalid_i = 1'b0; b_c = 0; end
         if (bus.m_axil_rready_o) begin bus.m_axil_rvalid_i = (r_c >= r_delay); r_c++; end
         else begin bus.m_axil_rvalid_i = 1'b0; r_c = 0; end
         if (bus.v_o) begin bus.ready_i = (o_c >= resp_delay); o_c++; end
         else begin bus.ready_i = 1'b0; o_c = 0; end
         bus.m_axil_bresp_i = slv_bresp;
         bus.m_axil_rresp_i = slv_rresp;
         bus.m_axil_rdata_i = slv_rdata;
      end
   end

   // Transaction model
   bit busy = 0, exp_err = 0;
   logic [31:0] exp_aw[$], exp_w[$], exp_ar[$], exp_resp[$];
   int pend_b = 0;
   int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, resp_hs_n = 0;
   int aw_vcycles = 0, last_aw_vcycles = 0, vo_cycles = 0, last_vo_cycles = 0;
   int acc_cyc = 0, last_lat = 0;
   logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0, last_resp = 0;
   logic prev_rst = 0, prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;
   logic prev_arv = 0, prev_arr = 0, prev_vo = 0, prev_ri = 0;
   logic [31:0] prev_awaddr = 0, prev_wdata = 0, prev_araddr = 0, prev_data = 0;

   always @(negedge clk_i) begin
      logic [31:0] ba, exp_v;
      bit clr_busy;
      clr_busy = 0;
      check1("ready_o_model", bus.ready_o, !busy);
      check1("error_o_model", bus.error_o, exp_err);
      if (!bus.v_o) check("data_o_idle", bus.data_o, 32'h0);
      if (prev_rst) begin
         check1("rst_awvalid", bus.m_axil_awvalid_o, 1'b0);
         check1("rst_wvalid", bus.m_axil_wvalid_o, 1'b0);
         check1("rst_arvalid", bus.m_axil_arvalid_o, 1'b0);
         check1("rst_v_o", bus.v_o, 1'b0);
      end else begin
         if (prev_awv && !prev_awr) begin
            check1("awvalid_held", bus.m_axil_awvalid_o, 1'b1);
            check("awaddr_stable", bus.m_axil_awaddr_o, prev_awaddr);
         end
         if (prev_wv && !prev_wr) begin
            check1("wvalid_held", bus.m_axil_wvalid_o, 1'b1);
            check("wdata_stable", bus.m_axil_wdata_o, prev_wdata);
         end
         if (prev_arv && !prev_arr) begin
            check1("arvalid_held", bus.m_axil_arvalid_o, 1'b1);
            check("araddr_stable", bus.m_axil_araddr_o, prev_araddr);
         end
         if (prev_vo && !prev_ri) begin
            check1("v_o_held", bus.v_o, 1'b1);
            check("data_o_stable", bus.data_o, prev_data);
         end
      end
      if (reset_i) begin
         busy = 0; exp_err = 0; pend_b = 0;
         exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_resp.delete();
         aw_vcycles = 0; vo_cycles = 0;
      end else begin
         if (bus.v_i && bus.ready_o) begin
            busy = 1;
            acc_cyc = cyc;
            ba = BASE + 32'(bus.data_i[30:16]) * 32'd4;
            if (bus.data_i[31]) begin
               exp_aw.push_back(ba);
               exp_w.push_back({16'h0, bus.data_i[15:0]});
               pend_b++;
            end else begin
               exp_ar.push_back(ba);
            end
         end
         if (bus.m_axil_awvalid_o && bus.m_axil_awready_i) begin
            aw_hs_n++;
            last_aw_vcycles = aw_vcycles + 1;
            aw_vcycles = 0;
            last_awaddr = bus.m_axil_awaddr_o;
            check1("aw_expected", exp_aw.size() > 0, 1'b1);
            if (exp_aw.size() > 0) check("awaddr", bus.m_axil_awaddr_o, exp_aw.pop_front());
            check("awprot", {29'b0, bus.m_axil_awprot_o}, 32'h0);
         end else if (bus.m_axil_awvalid_o) aw_vcycles++;
         if (bus.m_axil_wvalid_o && bus.m_axil_wready_i) begin
            w_hs_n++;
            last_wdata = bus.m_axil_wdata_o;
            check1("w_expected", exp_w.size() > 0, 1'b1);
            if (exp_w.size() > 0) check("wdata", bus.m_axil_wdata_o, exp_w.pop_front());
            check("wstrb", {28'b0, bus.m_axil_wstrb_o}, 32'hF);
         end
         if (bus.m_axil_bvalid_i && bus.m_axil_bready_o) begin
            b_hs_n++;
            check1("b_expected", pend_b > 0, 1'b1);
            if (pend_b > 0) pend_b--;
            if (bus.m_axil_bresp_i != 2'b00) exp_err = 1;
`ifdef BSG_AXIL_CMD_MASTER_WRITE_ACK_EN
            exp_resp.push_back({30'b0, bus.m_axil_bresp_i});
`else
            clr_busy = 1;
`endif
         end
         if (bus.m_axil_arvalid_o && bus.m_axil_arready_i) begin
            ar_hs_n++;
            last_araddr = bus.m_axil_araddr_o;
            check1("ar_expected", exp_ar.size() > 0, 1'b1);
            if (exp_ar.size() > 0) check("araddr", bus.m_axil_araddr_o, exp_ar.pop_front());
            check("arprot", {29'b0, bus.m_axil_arprot_o}, 32'h0);
         end
         if (bus.m_axil_rvalid_i && bus.m_axil_rready_o) begin
            exp_resp.push_back(bus.m_axil_rdata_i);
            if (bus.m_axil_rresp_i != 2'b00) exp_err = 1;
         end
         if (bus.v_o && bus.ready_i) begin
            resp_hs_n++;
            last_vo_cycles = vo_cycles + 1;
            vo_cycles = 0;
            last_resp = bus.data_o;
            last_lat = cyc - acc_cyc;
            check1("resp_expected", exp_resp.size() > 0, 1'b1);
            exp_v = (exp_resp.size() > 0) ? exp_resp.pop_front() : 32'hx;
            check("data_o", bus.data_o, exp_v);
            clr_busy = 1;
         end else if (bus.v_o) vo_cycles++;
         if (clr_busy) busy = 0;
      end
      prev_rst = reset_i;
      prev_awv = bus.m_axil_awvalid_o; prev_awr = bus.m_axil_awready_i; prev_awaddr = bus.m_axil_awaddr_o;
      prev_wv = bus.m_axil_wvalid_o; prev_wr = bus.m_axil_wready_i; prev_wdata = bus.m_axil_wdata_o;
      prev_arv = bus.m_axil_arvalid_o; prev_arr = bus.m_axil_arready_i; prev_araddr = bus.m_axil_araddr_o;
      prev_vo = bus.v_o; prev_ri = bus.ready_i; prev_data = bus.data_o;
   end

   task automatic send_cmd(input logic wr, input logic [14:0] a, input logic [15:0] d,
                           input bit hold, output int waited);
      bus.v_i = 1'b1;
      bus.data_i = {wr, a, d};
      waited = 0;
      while (!bus.ready_o && waited < 200) begin
         @(posedge clk_i); #1;
         waited++;
      end
      check1("cmd_accept_timeout", bus.ready_o, 1'b1);
      @(posedge clk_i); #1;
      if (!hold) bus.v_i = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(bus.ready_o && !bus.v_o && !bus.m_axil_awvalid_o && !bus.m_axil_wvalid_o &&
               !bus.m_axil_arvalid_o && !bus.m_axil_bready_o && !bus.m_axil_rready_o) && t < 300) begin
         @(posedge clk_i); #1;
         t++;
      end
      check1("idle_timeout", t < 300, 1'b1);
      @(posedge clk_i); #1;
   endtask

   initial begin
      int w, aw0, w0, b0, r0;
      bus.v_i = 1'b0;
      bus.data_i = 32'h0;
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      check1("reset_ready_o", bus.ready_o, 1'b1);
      check1("reset_v_o", bus.v_o, 1'b0);
      check1("reset_awvalid", bus.m_axil_awvalid_o, 1'b0);
      check1("reset_wvalid", bus.m_axil_wvalid_o, 1'b0);
      check1("reset_arvalid", bus.m_axil_arvalid_o, 1'b0);
      check1("reset_bready", bus.m_axil_bready_o, 1'b0);
      check1("reset_rready", bus.m_axil_rready_o, 1'b0);
      check1("reset_error_o", bus.error_o, 1'b0);

      // 1: simple write
      b0 = b_hs_n; r0 = resp_hs_n;
      send_cmd(1'b1, 15'h0004, 16'hBEEF, 0, w);
      wait_idle();
      check("t1_awaddr", last_awaddr, 32'h4000_0010);
      check("t1_wdata", last_wdata, 32'h0000_BEEF);
      check("t1_b_count", 32'(b_hs_n - b0), 32'd1);
`ifdef BSG_AXIL_CMD_MASTER_WRITE_ACK_EN
      check("t1_resp_count", 32'(resp_hs_n - r0), 32'd1);
      check("t1_ack", last_resp, 32'h0);
`else
      check("t1_resp_count", 32'(resp_hs_n - r0), 32'd0);
`endif

      // 2: AW delayed, W immediate
      aw_delay = 3;
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
      send_cmd(1'b1, 15'h0100, 16'h1234, 0, w);
      wait_idle();
      check("t2_aw_valid_cycles", 32'(last_aw_vcycles), 32'd4);
      check("t2_awaddr", last_awaddr, 32'h4000_0400);
      check("t2_aw_count", 32'(aw_hs_n - aw0), 32'd1);
      check("t2_w_count", 32'(w_hs_n - w0), 32'd1);
      check("t2_b_count", 32'(b_hs_n - b0), 32'd1);
      aw_delay = 0;

      // 3: read with stalled response consumer
      resp_delay = 5;
      slv_rdata = 32'h1234_5678;
      send_cmd(1'b0, 15'h7FFF, 16'h0, 0, w);
      wait_idle();
      check("t3_araddr", last_araddr, 32'h4001_FFFC);
      check("t3_rdata", last_resp, 32'h1234_5678);
      check("t3_v_o_cycles", 32'(last_vo_cycles), 32'd6);
      resp_delay = 0;

      // 4: SLVERR read, then OKAY traffic keeps error sticky
      slv_rresp = 2'b10;
      slv_rdata = 32'hCAFE_F00D;
      send_cmd(1'b0, 15'h0010, 16'h0, 0, w);
      wait_idle();
      check("t4_err_rdata", last_resp, 32'hCAFE_F00D);
      check1("t4_error_set", bus.error_o, 1'b1);
      slv_rresp = 2'b00;
      slv_rdata = 32'h0BAD_BEEF;
      send_cmd(1'b0, 15'h0011, 16'h0, 0, w);
      wait_idle();
      check("t4_ok_rdata", last_resp, 32'h0BAD_BEEF);
      send_cmd(1'b1, 15'h0012, 16'h00FF, 0, w);
      wait_idle();
      check1("t4_error_sticky", bus.error_o, 1'b1);

      // 5: back-to-back with v_i held high
      slv_rdata = 32'hA5A5_5A5A;
      send_cmd(1'b1, 15'h0020, 16'h5555, 1, w);
      send_cmd(1'b0, 15'h0021, 16'h0, 0, w);
`ifdef BSG_AXIL_CMD_MASTER_WRITE_ACK_EN
      check("t5_busy_cycles", 32'(w), 32'd3);
`else
      check("t5_busy_cycles", 32'(w), 32'd2);
`endif
      wait_idle();
      check("t5_araddr", last_araddr, 32'h4000_0084);
      check("t5_rdata", last_resp, 32'hA5A5_5A5A);
      check("t5_read_latency", 32'(last_lat), 32'd3);

      // 6: reset with AW done and W pending
      w_delay = 10;
      aw0 = aw_hs_n;
      send_cmd(1'b1, 15'h0030, 16'hAAAA, 0, w);
      @(posedge clk_i); #1;
      check("t6_aw_done", 32'(aw_hs_n - aw0), 32'd1);
      check1("t6_w_pending", bus.m_axil_wvalid_o, 1'b1);
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      check1("t6_wvalid_dropped", bus.m_axil_wvalid_o, 1'b0);
      check1("t6_awvalid_low", bus.m_axil_awvalid_o, 1'b0);
      check1("t6_ready_o", bus.ready_o, 1'b1);
      check1("t6_error_cleared", bus.error_o, 1'b0);
      w_delay = 0;
      aw0 = aw_hs_n; w0 = w_hs_n;
      send_cmd(1'b1, 15'h0031, 16'h7777, 0, w);
      wait_idle();
      check("t6_aw_fresh", 32'(aw_hs_n - aw0), 32'd1);
      check("t6_w_fresh", 32'(w_hs_n - w0), 32'd1);
      check("t6_awaddr", last_awaddr, 32'h4000_00C4);
      check("t6_wdata", last_wdata, 32'h0000_7777);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
